// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer: fetch-to-decode register stage with a two-entry skid buffer,
// registered in_ready and flush on redirect.
module if_id_skid_buffer #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_pc_i,
  input  logic [INST_W-1:0] in_inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [INST_W-1:0] out_inst_o
);
  typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b11} state_e;
  state_e state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic accept, consume;
  assign accept      = in_valid_i & in_ready_q;
  assign consume     = out_valid_o & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = state_q != EMPTY;
  assign out_pc_o    = main_pc_q;
  assign out_inst_o  = out_valid_o ? main_inst_q : NOP_INST;
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    // Flush drops everything; main data is left alone so out_pc keeps its value.
    if (flush_i) state_d = EMPTY;
    else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d     = BUSY;
          main_pc_d   = in_pc_i;
          main_inst_d = in_inst_i;
        end
        BUSY: if (accept && consume) begin
          main_pc_d   = in_pc_i;
          main_inst_d = in_inst_i;
        end else if (accept) begin
          state_d     = FULL;
          skid_pc_d   = in_pc_i;
          skid_inst_d = in_inst_i;
        end else if (consume) state_d = EMPTY;
        FULL: if (consume) begin
          state_d     = BUSY;
          main_pc_d   = skid_pc_q;
          main_inst_d = skid_inst_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end
endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb_if_id_skid_buffer: directed and random checks of the IF/ID skid buffer
// against a two-deep FIFO reference model.
module tb_if_id_skid_buffer;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} entry_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_inst = 0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  entry_t q[$];
  logic [31:0] last_pc = 0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  if_id_skid_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_pc_i(in_pc), .in_inst_i(in_inst),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc), .out_inst_o(out_inst)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    chk({tag, ".out_pc"}, out_pc, q.size() > 0 ? q[0].pc : last_pc);
    chk({tag, ".out_inst"}, out_inst, q.size() > 0 ? q[0].inst : NOP);
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
  endtask
  // One clock: the model steps on the edge, outputs are checked at the following negedge.
  task automatic cyc(input string tag);
    bit acc, con;
    entry_t e;
    acc = in_valid && q.size() < 2;
    con = out_ready && q.size() > 0;
    e.pc = in_pc; e.inst = in_inst;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last_pc = q[0].pc;
    @(negedge clk);
    chk_all(tag);
  endtask
  initial begin
    bit pend;
    bit acc;
    // 1. reset
    repeat (3) @(negedge clk);
    chk_all("reset");
    chk("reset.nop", out_inst, 32'h0000_0013);
    rst_n = 1;
    // 2. streaming
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 32'hA0 + 32'(i), 1, 0);
      cyc("stream");
    end
    drive(0, 0, 0, 1, 0);
    cyc("stream_drain");
    // 3. stall fill
    drive(1, 32'h10, 32'h1010, 0, 0); cyc("fill_busy");
    drive(1, 32'h14, 32'h1414, 0, 0); cyc("fill_full");
    chk("fill.in_ready_low", 32'(in_ready), 0);
    drive(0, 0, 0, 0, 0); cyc("fill_hold");
    drive(0, 0, 0, 1, 0); cyc("drain1");
    chk("drain1.pc14", out_pc, 32'h14);
    cyc("drain2");
    // 4. flush in FULL with in_valid
    drive(1, 32'h20, 32'h2020, 0, 0); cyc("f4a");
    drive(1, 32'h24, 32'h2424, 0, 0); cyc("f4b");
    drive(1, 32'h18, 32'h1818, 0, 1); cyc("flush_full");
    chk("flush_full.nop", out_inst, NOP);
    drive(0, 0, 0, 1, 0); cyc("flush_full_after");
    // 5. flush + consume in BUSY
    drive(1, 32'h30, 32'h3030, 0, 0); cyc("f5a");
    drive(0, 0, 0, 1, 1); cyc("flush_busy");
    drive(1, 32'h100, 32'h0100_0100, 0, 0); cyc("post_flush");
    chk("post_flush.pc", out_pc, 32'h100);
    drive(0, 0, 0, 1, 0); cyc("post_flush_consume");
    // 6. async reset mid-cycle in FULL
    drive(1, 32'h40, 32'h4040, 0, 0); cyc("f6a");
    drive(1, 32'h44, 32'h4444, 0, 0); cyc("f6b");
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1 q.delete(); last_pc = 0;
    chk_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 1, 0); cyc("after_rst");
    // random phase
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        pend = $urandom_range(0, 3) != 0;
        in_pc = $urandom; in_inst = $urandom;
      end
      in_valid = pend;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      acc = pend && q.size() < 2;
      cyc("rand");
      if (acc) pend = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
